keypad_scan_fifo: RTL and testbench
===================================

# keypad_scan_fifo

Parametrised successor of the 4x4 keypad scanner: drives active-low column strobes, samples active-low row returns, debounces over whole scans and queues accepted key codes in a small FIFO. The FIFO head is shown on a seven-segment digit. Sits between the board keypad pins and the user logic / display, replacing the fixed 4x4 non-buffered scanner.

## Interface
- ROWS, 4, number of row inputs (2..8)
- COLS, 4, number of column strobes (2..8)
- SCAN_DIV, 4, clock cycles each column is driven (>= 3)
- DEB_SCANS, 2, consecutive identical scans needed to accept a press or release (>= 1)
- FIFO_DEPTH, 4, key codes buffered (power of two, >= 2)

- clk  in  1  single system clock, rising edge
- res  in  1  reset, synchronous, active-low
- SW_R  in  ROWS  row returns, active-low (1 = idle), asynchronous to clk
- SW_C  out  COLS  column strobes, one-hot-low
- key_rd  in  1  pop FIFO head; ignored when empty
- key_code  out  CW = clog2(ROWS*COLS)  FIFO head code = row*COLS + col
- key_valid  out  1  FIFO non-empty
- key_count  out  clog2(FIFO_DEPTH)+1  entries held
- overflow  out  1  sticky: a press was dropped on a full FIFO
- out7  out  7  active-low gfedcba segments of head, hex 0..F
- out1  out  1  debounced "a key is down" level

## Operation
- SW_R passes a 2-flop synchroniser before any use.
- Column counter col cycles 0..COLS-1, holding each value SCAN_DIV cycles; SW_C = ~(1 << col). After COLS-1 wraps to 0.
- In the last dwell cycle of each column, synchronised rows are sampled; any low row marks a hit. Lowest code hit in a scan wins (multi-key: lowest code only).
- Scan result at col wrap: code K or NONE. Debouncer holds candidate + run counter; counter resets when result differs from candidate, saturates at DEB_SCANS.
- Accepted state changes when run reaches DEB_SCANS: NONE→K or K1→K2 (K2≠K1) issues one push of K/K2; K→NONE issues nothing. Holding a key never repeats.
- out1 = accepted state ≠ NONE.
- FIFO: push on accept event, pop on key_rd & key_valid. Push while full and no pop: code dropped, overflow set until reset. Push + pop same cycle: both happen, count unchanged (including full).
- out7 = decode(key_code) when key_valid, else 7'h7F (blank).

## Timing
- Reset (res=0 at a clk edge): col=0, SW_C=~1, synchroniser and debouncer cleared (candidate NONE, run 0, accepted NONE), FIFO empty; key_code=0, key_valid=0, key_count=0, overflow=0, out7=7'h7F, out1=0. Applies mid-scan; scanning restarts at column 0 on the first edge with res=1.
- Scan period = COLS*SCAN_DIV cycles (16 by default).
- Push happens on the clk edge at the end of the confirming scan; key_valid, key_code, out7, out1 update on that same edge (registered outputs, no extra stage).
- Pop: key_code/out7 show next entry on the edge after key_rd sampled high.
- Minimum press detected: DEB_SCANS full scans of stable rows after synchroniser delay.

## Structure
- Package keypad_pkg: seven-segment hex decode function, SEG_BLANK = 7'h7F, NONE code encoding (extra flag bit, not a valid code).
- Sub-module key_fifo: synchronous FIFO (width CW, depth FIFO_DEPTH, simultaneous push/pop, full/empty/count). Scanner and debouncer live in the top.

## Test plan
Defaults (4x4, SCAN_DIV=4, DEB_SCANS=2, depth 4); keypad model drives SW_R from SW_C.
- Reset: res=0 one edge → SW_C=4'b1110, out7=7'h7F, key_valid=0, out1=0, key_count=0.
- Key row1/col2 held 4 scans → exactly one push, key_code=6, out7=seg('6'), out1=1; release 2 scans → out1=0, no second push.
- Bounce: key row0/col0 present one scan only → no push, out1 stays 0.
- Five distinct presses (codes 1,2,3,4,5), no pops → key_count=4, overflow=1, head=1; pop four times → codes 1,2,3,4 then key_valid=0, out7=7'h7F.
- FIFO full, key_rd high on the push edge of code 9 → key_count stays 4, overflow=0, tail=9.
- Key held, res=0 mid-scan (col 2) → all outputs at reset values; after release of res, key re-accepted after 2 scans and pushed once.

Source files
------------

// File: rtl/keypad_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : keypad_pkg
//  Description : Shared constants and the hex seven-segment decoder for the
//                keypad scanner.
//  Revision    : 1.0  initial release
// ============================================================================
package keypad_pkg;

  // Segment pattern that lights nothing (segments are active-low).
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Scan results carry one flag bit above the key code. When that bit is set,
  // the word means "no key"; it never equals a real code, and it compares
  // greater than every real code.
  localparam logic NONE_FLAG = 1'b1;

  // Hex digit to active-low gfedcba segments.
  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    logic [6:0] seg_on;
    case (nib)
      4'h0:    seg_on = 7'h3F;
      4'h1:    seg_on = 7'h06;
      4'h2:    seg_on = 7'h5B;
      4'h3:    seg_on = 7'h4F;
      4'h4:    seg_on = 7'h66;
      4'h5:    seg_on = 7'h6D;
      4'h6:    seg_on = 7'h7D;
      4'h7:    seg_on = 7'h07;
      4'h8:    seg_on = 7'h7F;
      4'h9:    seg_on = 7'h6F;
      4'hA:    seg_on = 7'h77;
      4'hB:    seg_on = 7'h7C;
      4'hC:    seg_on = 7'h39;
      4'hD:    seg_on = 7'h5E;
      4'hE:    seg_on = 7'h79;
      default: seg_on = 7'h71;
    endcase
    return ~seg_on;
  endfunction

endpackage
`default_nettype wire

// File: rtl/key_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : key_fifo
//  Description : Small synchronous FIFO for accepted key codes. Simultaneous
//                push and pop are both honoured, including when full. A push
//                that cannot be stored sets a sticky overflow flag.
//  Revision    : 1.0  initial release
// ============================================================================
module key_fifo
  import keypad_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     res,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  output logic [WIDTH-1:0]         dout,
  output logic                     valid,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] c_ptr_one = {{(AW-1){1'b0}}, 1'b1};
  localparam logic [AW:0]   c_cnt_one = {{AW{1'b0}}, 1'b1};
  localparam logic [AW:0]   c_cnt_full = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             r_overflow;

  logic w_empty;
  logic w_full;
  logic w_do_pop;
  logic w_do_push;

  // Occupancy flags and the qualified push/pop strobes.
  always_comb begin
    w_empty   = (r_count == '0);
    w_full    = (r_count == c_cnt_full);
    w_do_pop  = pop & ~w_empty;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    w_do_push = push & (~w_full | w_do_pop);
  end

  // Storage, pointers, occupancy and sticky overflow.
  always_ff @(posedge clk) begin
    if (!res) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_do_push) begin
        r_mem[r_wr_ptr] <= din;
        r_wr_ptr        <= r_wr_ptr + c_ptr_one;
      end
      if (w_do_pop) r_rd_ptr <= r_rd_ptr + c_ptr_one;
      if (w_do_push && !w_do_pop)      r_count <= r_count + c_cnt_one;
      else if (w_do_pop && !w_do_push) r_count <= r_count - c_cnt_one;
      if (push && !w_do_push) r_overflow <= 1'b1;
    end
  end

  assign dout     = r_mem[r_rd_ptr];
  assign valid    = ~w_empty;
  assign count    = r_count;
  assign overflow = r_overflow;

endmodule
`default_nettype wire

// File: rtl/keypad_scan_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : keypad_scan_fifo
//  Description : Matrix keypad scanner with whole-scan debouncing and a key
//                code FIFO. The FIFO head is shown on a seven-segment digit.
//  Revision    : 1.0  initial release
// ============================================================================
module keypad_scan_fifo
  import keypad_pkg::*;
#(
  parameter int ROWS       = 4,
  parameter int COLS       = 4,
  parameter int SCAN_DIV   = 4,
  parameter int DEB_SCANS  = 2,
  parameter int FIFO_DEPTH = 4,
  localparam int CW        = $clog2(ROWS*COLS),
  localparam int KCW       = $clog2(FIFO_DEPTH) + 1
) (
  input  logic            clk,
  input  logic            res,
  input  logic [ROWS-1:0] SW_R,
  output logic [COLS-1:0] SW_C,
  input  logic            key_rd,
  output logic [CW-1:0]   key_code,
  output logic            key_valid,
  output logic [KCW-1:0]  key_count,
  output logic            overflow,
  output logic [6:0]      out7,
  output logic            out1
);

  localparam int CWP  = CW + 1;
  localparam int COLW = $clog2(COLS);
  localparam int DIVW = $clog2(SCAN_DIV);
  localparam int RUNW = $clog2(DEB_SCANS + 1);

  localparam logic [CW:0]     c_none     = {NONE_FLAG, {CW{1'b0}}};
  localparam logic [DIVW-1:0] c_div_last = DIVW'(SCAN_DIV - 1);
  localparam logic [DIVW-1:0] c_div_one  = DIVW'(1);
  localparam logic [COLW-1:0] c_col_last = COLW'(COLS - 1);
  localparam logic [COLW-1:0] c_col_one  = COLW'(1);
  localparam logic [RUNW-1:0] c_deb      = RUNW'(DEB_SCANS);
  localparam logic [RUNW-1:0] c_run_one  = RUNW'(1);

  logic [ROWS-1:0] r_sync1, r_sync2;
  logic [DIVW-1:0] r_div;
  logic [COLW-1:0] r_col;
  logic [CW:0]     r_best;
  logic [CW:0]     r_cand;
  logic [RUNW-1:0] r_run;
  logic [CW:0]     r_acc;

  logic            w_last_dwell;
  logic            w_wrap;
  logic [CW:0]     w_col_hit;
  logic [CW:0]     w_scan_min;
  logic [RUNW-1:0] w_next_run;
  logic            w_accept;
  logic            w_push;
  logic [3:0]      w_nib;

  // Two-flop synchroniser for the asynchronous row returns (idle high).
  always_ff @(posedge clk) begin
    if (!res) begin
      r_sync1 <= '1;
      r_sync2 <= '1;
    end else begin
      r_sync1 <= SW_R;
      r_sync2 <= r_sync1;
    end
  end

  // Per-column hit, running scan minimum and debounce next-state terms.
  always_comb begin
    w_last_dwell = (r_div == c_div_last);
    w_wrap       = w_last_dwell && (r_col == c_col_last);
    // Walk rows downward so the lowest pressed row is the one left standing.
    w_col_hit = c_none;
    for (int r = ROWS - 1; r >= 0; r--) begin
      if (!r_sync2[r]) w_col_hit = CWP'(r * COLS + int'(r_col));
    end
    // NONE sorts above every real code, so a plain minimum keeps the lowest.
    w_scan_min = (w_col_hit < r_best) ? w_col_hit : r_best;
    if (w_scan_min != r_cand)  w_next_run = c_run_one;
    else if (r_run == c_deb)   w_next_run = r_run;
    else                       w_next_run = r_run + c_run_one;
    w_accept = w_wrap && (w_next_run == c_deb) && (w_scan_min != r_acc);
    // Only transitions to a real key enqueue; releases do not.
    w_push   = w_accept && !w_scan_min[CW];
  end

  // Column strobe timing and per-scan hit accumulation.
  always_ff @(posedge clk) begin
    if (!res) begin
      r_div  <= '0;
      r_col  <= '0;
      r_best <= c_none;
    end else if (w_last_dwell) begin
      r_div  <= '0;
      r_col  <= (r_col == c_col_last) ? '0 : r_col + c_col_one;
      r_best <= w_wrap ? c_none : w_scan_min;
    end else begin
      r_div  <= r_div + c_div_one;
    end
  end

  // Whole-scan debouncer: candidate, run length and accepted state.
  always_ff @(posedge clk) begin
    if (!res) begin
      r_cand <= c_none;
      r_run  <= '0;
      r_acc  <= c_none;
    end else if (w_wrap) begin
      r_cand <= w_scan_min;
      r_run  <= w_next_run;
      if (w_accept) r_acc <= w_scan_min;
    end
  end

  key_fifo #(
    .WIDTH (CW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .res      (res),
    .push     (w_push),
    .din      (w_scan_min[CW-1:0]),
    .pop      (key_rd),
    .dout     (key_code),
    .valid    (key_valid),
    .count    (key_count),
    .overflow (overflow)
  );

  assign SW_C  = ~(COLS'(1) << r_col);
  assign out1  = (r_acc != c_none);
  assign w_nib = 4'(key_code);
  assign out7  = key_valid ? hex_to_seg(w_nib) : SEG_BLANK;

endmodule
`default_nettype wire

// File: tb/tb_keypad_scan_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : tb_keypad_scan_fifo
//  Description : Directed bench for keypad_scan_fifo with a single-key keypad
//                model. Presses are aligned to scan boundaries so push edges
//                are known exactly.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_keypad_scan_fifo;

  localparam int SCAN = 16;

  logic       clk = 1'b0;
  logic       res;
  logic [3:0] SW_R;
  logic [3:0] SW_C;
  logic       key_rd;
  logic [3:0] key_code;
  logic       key_valid;
  logic [2:0] key_count;
  logic       overflow;
  logic [6:0] out7;
  logic       out1;

  logic key_down;
  int   key_row;
  int   key_col;
  int   cyc;
  int   n_vec  = 0;
  int   n_miss = 0;

  keypad_scan_fifo dut (
    .clk       (clk),
    .res       (res),
    .SW_R      (SW_R),
    .SW_C      (SW_C),
    .key_rd    (key_rd),
    .key_code  (key_code),
    .key_valid (key_valid),
    .key_count (key_count),
    .overflow  (overflow),
    .out7      (out7),
    .out1      (out1)
  );

  always #5 clk = ~clk;

  // Keypad model: the held key pulls its row low while its column is strobed.
  always_comb begin
    SW_R = 4'hF;
    if (key_down && !SW_C[key_col]) SW_R[key_row] = 1'b0;
  end

  // Bench scan-phase counter: edges since reset release; wraps on multiples of 16.
  always_ff @(posedge clk) begin
    if (!res) cyc <= 0;
    else      cyc <= cyc + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_wrap();
    do tick(1); while (cyc % SCAN != 0);
  endtask

  task automatic apply_reset();
    res = 1'b0;
    tick(1);
    res = 1'b1;
  endtask

  task automatic key_on(input int r, input int c);
    key_row  = r;
    key_col  = c;
    key_down = 1'b1;
  endtask

  // Press for three scans starting at a wrap, then release for three scans.
  task automatic press_aligned(input int r, input int c);
    wait_wrap();
    key_on(r, c);
    tick(3 * SCAN);
    key_down = 1'b0;
    tick(3 * SCAN);
  endtask

  task automatic pop_one();
    key_rd = 1'b1;
    tick(1);
    key_rd = 1'b0;
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_swc"},   SW_C,      4'b1110);
    check({tag, "_out7"},  out7,      7'h7F);
    check({tag, "_valid"}, key_valid, 1'b0);
    check({tag, "_out1"},  out1,      1'b0);
    check({tag, "_count"}, key_count, 3'd0);
    check({tag, "_ovf"},   overflow,  1'b0);
    check({tag, "_code"},  key_code,  4'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic seen;
    res      = 1'b0;
    key_rd   = 1'b0;
    key_down = 1'b0;
    key_row  = 0;
    key_col  = 0;

    // Reset values
    tick(2);
    res = 1'b0;
    tick(1);
    check_reset_state("reset");
    res = 1'b1;
    tick(SCAN * 3);

    // Key row1/col2 (code 6): push lands exactly two scans after the press
    wait_wrap();
    key_on(1, 2);
    tick(2 * SCAN - 1);
    check("k6_pre_count", key_count, 3'd0);
    check("k6_pre_out1",  out1,      1'b0);
    tick(1);
    check("k6_count", key_count, 3'd1);
    check("k6_code",  key_code,  4'd6);
    check("k6_out7",  out7,      7'h02);
    check("k6_out1",  out1,      1'b1);
    tick(2 * SCAN);
    check("k6_hold_count", key_count, 3'd1);
    wait_wrap();
    key_down = 1'b0;
    tick(2 * SCAN - 1);
    check("k6_rel_pre_out1", out1, 1'b1);
    tick(1);
    check("k6_rel_out1",  out1,      1'b0);
    check("k6_rel_count", key_count, 3'd1);
    pop_one();
    check("k6_pop_valid", key_valid, 1'b0);
    check("k6_pop_out7",  out7,      7'h7F);

    // Bounce: code 0 present for a single scan
    wait_wrap();
    key_on(0, 0);
    seen = 1'b0;
    for (int i = 0; i < 5 * SCAN; i++) begin
      if (i == SCAN) key_down = 1'b0;
      tick(1);
      if (out1) seen = 1'b1;
    end
    check("bounce_out1",  seen,      1'b0);
    check("bounce_count", key_count, 3'd0);

    // Five distinct presses without pops: fifth one overflows
    press_aligned(0, 1);
    press_aligned(0, 2);
    press_aligned(0, 3);
    press_aligned(1, 0);
    press_aligned(1, 1);
    check("ovf_count", key_count, 3'd4);
    check("ovf_flag",  overflow,  1'b1);
    check("ovf_head",  key_code,  4'd1);
    check("ovf_out7",  out7,      7'h79);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("drain_code%0d", i), key_code, 32'(i + 1));
      pop_one();
    end
    check("drain_valid", key_valid, 1'b0);
    check("drain_out7",  out7,      7'h7F);
    check("drain_ovf",   overflow,  1'b1);

    // Full FIFO, pop on the push edge of code 9 (row2/col1)
    apply_reset();
    check("rst2_ovf", overflow, 1'b0);
    press_aligned(0, 1);
    press_aligned(0, 2);
    press_aligned(0, 3);
    press_aligned(1, 0);
    check("full_count", key_count, 3'd4);
    wait_wrap();
    key_on(2, 1);
    tick(2 * SCAN - 1);
    key_rd = 1'b1;
    tick(1);
    key_rd = 1'b0;
    check("pp_count", key_count, 3'd4);
    check("pp_ovf",   overflow,  1'b0);
    check("pp_head",  key_code,  4'd2);
    check("pp_out1",  out1,      1'b1);
    key_down = 1'b0;
    tick(3 * SCAN);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("pp_drain%0d", i), key_code, 32'(i + 2));
      pop_one();
    end
    check("pp_tail",      key_code, 4'd9);
    check("pp_tail_out7", out7,     7'h10);
    pop_one();
    check("pp_empty", key_valid, 1'b0);

    // Reset mid-scan (column 2) with the key held
    wait_wrap();
    key_on(1, 2);
    tick(2 * SCAN);
    check("mid_pushed", key_count, 3'd1);
    tick(8);
    check("mid_col2", SW_C, 4'b1011);
    res = 1'b0;
    tick(1);
    check_reset_state("mid_rst");
    res = 1'b1;
    tick(2 * SCAN - 1);
    check("mid_pre_count", key_count, 3'd0);
    tick(1);
    check("mid_count", key_count, 3'd1);
    check("mid_code",  key_code,  4'd6);
    check("mid_out1",  out1,      1'b1);
    tick(2 * SCAN);
    check("mid_once", key_count, 3'd1);
    key_down = 1'b0;
    tick(2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
`default_nettype wire
